rm_wb_engine: RTL and testbench
===============================

// Module: rm_wb_engine
// PURPOSE
//  Parametrised reconfigurable-module block on the crossbar: Wishbone slave register file plus a Wishbone master
//  fill/copy engine and a maskable IRQ aggregator. Software programs SRC/DST/LEN, starts the engine, and gets
//  irq_out on completion or bus error. Drop-in for the RM0 slot; pipelined WB, one outstanding master transaction.
// PARAMETERS
//  MADR_W  28  master word-address width (wbm_adr_o)
//  SADR_W  20  slave word-address width (wbs_adr); registers decoded from wbs_adr[2:0], upper bits ignored
//  LEN_W   16  transfer length counter width (words); max LEN = 2**LEN_W-1
// PORTS
//  sys_clk      in   1        system clock, all logic on rising edge
//  rst_n        in   1        synchronous active-low reset
//  wbm_adr_o    out  MADR_W   master word address
//  wbm_dat_o    out  32       master write data
//  wbm_dat_i    in   32       master read data
//  wbm_we_o     out  1        master write enable
//  wbm_sel_o    out  4        byte selects, always 4'hF while stb
//  wbm_stb_o    out  1        master strobe
//  wbm_ack_i    in   1        master ack
//  wbm_stall_i  in   1        master stall
//  wbm_cyc_o    out  1        master cycle
//  wbm_err_i    in   1        master bus error
//  wbs_adr      in   SADR_W   slave word address
//  wbs_dat_w    in   32       slave write data
//  wbs_dat_r    out  32       slave read data
//  wbs_sel      in   4        slave byte selects (byte-wise writes honoured)
//  wbs_stall    out  1        slave stall, tied 0
//  wbs_cyc      in   1        slave cycle
//  wbs_stb      in   1        slave strobe
//  wbs_ack      out  1        slave ack
//  wbs_we       in   1        slave write enable
//  wbs_err      out  1        slave error, tied 0
//  irq_in       in   32       system IRQ inputs (level)
//  irq_out      out  1        aggregated IRQ (level)
// BEHAVIOUR
//  Reset: all outputs 0; regs 0; FSM IDLE. Reset mid-transfer aborts: cyc/stb drop the following cycle, no DONE.
//  Slave: wbs_ack=1 exactly one cycle after each cycle with wbs_cyc&wbs_stb; read data valid with ack; unmapped=0.
//  Regs (wbs_adr[2:0]): 0 CTRL[0]=START (write-1 pulse, reads 0), [1]=MODE (0 fill,1 copy), [2]=IRQ_EN
//   1 STATUS [0]=BUSY (RO), [1]=DONE (W1C), [2]=ERR (W1C)   2 SRC   3 DST   4 LEN[LEN_W-1:0]
//   5 PATTERN   6 IRQ_MASK   7 IRQ_PEND = irq_in & IRQ_MASK (RO)
//  START while BUSY ignored. START clears DONE/ERR, loads working src/dst/count from SRC/DST/LEN.
//  LEN=0: no bus activity, DONE set the cycle after START.
//  FSM: IDLE -> (copy) RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> RD_REQ|FIN ; (fill) WR_REQ -> WR_WAIT -> WR_REQ|FIN
//   *_REQ: cyc=1, stb=1, adr/we/dat driven; leave when wbm_stall_i=0 (stb drops next cycle, cyc held).
//   *_WAIT: cyc=1, stb=0; on wbm_ack_i advance (RD latches wbm_dat_i); cyc drops for one cycle between words.
//   Write data: fill -> PATTERN; copy -> latched read word. src/dst +1 per word, wrap modulo 2**MADR_W.
//   wbm_err_i in any state with cyc: abort, ERR=1, DONE=1, go IDLE. ack and err same cycle: err wins.
//   FIN: DONE=1, BUSY=0, back to IDLE. BUSY=1 from cycle after START until FIN/abort.
//  irq_out = (IRQ_EN & (DONE|ERR)) | |(irq_in & IRQ_MASK); combinational from regs, registered inputs only.
//  Software W1C of DONE same cycle as engine sets DONE: set wins.
// TESTING
//  1 reset: rst_n=0 2 cycles -> all outputs 0, every reg reads 0, wbs_ack one cycle after each read.
//  2 fill: DST=0x100,LEN=4,PATTERN=0xA5A5A5A5,START -> 4 writes adr 0x100..0x103, DONE=1, irq_out=1 if IRQ_EN.
//  3 copy with stall: SRC=0x200,DST=0x300,LEN=3, slave stalls 2 cycles/req -> 0x300..2 == mem 0x200..2, no dup stb.
//  4 error: copy LEN=8, wbm_err_i on 3rd read -> cyc drops, STATUS=0b110, only 2 writes issued.
//  5 edge: LEN=0 -> no cyc, DONE next cycle; START while BUSY ignored; DST=2**MADR_W-1,LEN=2 wraps to 0.
//  6 irq: IRQ_MASK=0x10, irq_in=0x30 -> IRQ_PEND=0x10, irq_out=1; mask 0 -> irq_out=0; rst_n mid-copy -> cyc=0 next.

Source files
------------

// File: rtl/rm_wb_engine.sv
// Reconfigurable-module engine: Wishbone slave register file, a single-outstanding
// pipelined Wishbone master fill/copy engine, and a maskable IRQ aggregator.
module rm_wb_engine #(
    parameter int MADR_W = 28,
    parameter int SADR_W = 20,
    parameter int LEN_W  = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    output logic [MADR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_stb_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_stall_i,
    output logic              wbm_cyc_o,
    input  logic              wbm_err_i,
    input  logic [SADR_W-1:0] wbs_adr,
    input  logic [31:0]       wbs_dat_w,
    output logic [31:0]       wbs_dat_r,
    input  logic [3:0]        wbs_sel,
    output logic              wbs_stall,
    input  logic              wbs_cyc,
    input  logic              wbs_stb,
    output logic              wbs_ack,
    input  logic              wbs_we,
    output logic              wbs_err,
    input  logic [31:0]       irq_in,
    output logic              irq_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0]  CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [MADR_W-1:0] ADR_ONE = {{(MADR_W-1){1'b0}}, 1'b1};

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel_v);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel_v[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t            state_r, state_nxt_s;
    logic              ctrl_mode_r, ctrl_irq_en_r, done_r, err_r;
    logic [31:0]       src_reg_r, dst_reg_r, pattern_r, irq_mask_r, irq_in_r;
    logic [LEN_W-1:0]  len_reg_r, cnt_r;
    logic [MADR_W-1:0] src_w_r, dst_w_r;
    logic              mode_w_r;
    logic [31:0]       rd_word_r;
    logic              cyc_r, stb_r, we_r;
    logic [3:0]        sel_r;
    logic [MADR_W-1:0] adr_r;
    logic [31:0]       dat_r;
    logic              cyc_nxt_s, stb_nxt_s, we_nxt_s;
    logic [MADR_W-1:0] adr_nxt_s;
    logic [31:0]       dat_nxt_s;
    logic              rd_ack_s, wr_ack_s, fin_s, abort_s;
    logic              slv_req_s, slv_wr_s, start_ok_s, w1c_done_s, w1c_err_s, busy_s;
    logic [2:0]        reg_sel_s;
    logic [31:0]       rd_mux_s, len_merge_s;
    logic              slv_ack_r;
    logic [31:0]       slv_dat_r;
    logic              unused_s;

    assign slv_req_s   = wbs_cyc & wbs_stb;
    assign slv_wr_s    = slv_req_s & wbs_we;
    assign reg_sel_s   = wbs_adr[2:0];
    assign busy_s      = (state_r != ST_IDLE);
    assign start_ok_s  = slv_wr_s && (reg_sel_s == 3'd0) && wbs_sel[0] && wbs_dat_w[0] && !busy_s;
    assign w1c_done_s  = slv_wr_s && (reg_sel_s == 3'd1) && wbs_sel[0] && wbs_dat_w[1];
    assign w1c_err_s   = slv_wr_s && (reg_sel_s == 3'd1) && wbs_sel[0] && wbs_dat_w[2];
    assign len_merge_s = byte_merge({{(32-LEN_W){1'b0}}, len_reg_r}, wbs_dat_w, wbs_sel);
    assign unused_s    = ^{wbs_adr[SADR_W-1:3], src_reg_r[31:MADR_W], dst_reg_r[31:MADR_W],
                           len_merge_s[31:LEN_W]};

    // Engine next-state and next bus outputs; a *_REQ entered with stb low is the idle gap between words
    always_comb begin
        state_nxt_s = state_r;
        cyc_nxt_s   = cyc_r;
        stb_nxt_s   = stb_r;
        we_nxt_s    = we_r;
        adr_nxt_s   = adr_r;
        dat_nxt_s   = dat_r;
        rd_ack_s    = 1'b0;
        wr_ack_s    = 1'b0;
        fin_s       = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    if (len_reg_r == '0) begin
                        fin_s = 1'b1;
                    end else if (wbs_dat_w[1]) begin
                        state_nxt_s = ST_RD_REQ;
                        cyc_nxt_s   = 1'b1;
                        stb_nxt_s   = 1'b1;
                        we_nxt_s    = 1'b0;
                        adr_nxt_s   = src_reg_r[MADR_W-1:0];
                    end else begin
                        state_nxt_s = ST_WR_REQ;
                        cyc_nxt_s   = 1'b1;
                        stb_nxt_s   = 1'b1;
                        we_nxt_s    = 1'b1;
                        adr_nxt_s   = dst_reg_r[MADR_W-1:0];
                        dat_nxt_s   = pattern_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (!stb_r) begin
                    cyc_nxt_s = 1'b1;
                    stb_nxt_s = 1'b1;
                    we_nxt_s  = 1'b0;
                    adr_nxt_s = src_w_r;
                end else if (!wbm_stall_i) begin
                    stb_nxt_s   = 1'b0;
                    state_nxt_s = ST_RD_WAIT;
                end else begin
                    state_nxt_s = ST_RD_REQ;
                end
            end
            ST_RD_WAIT: begin
                if (wbm_ack_i) begin
                    rd_ack_s    = 1'b1;
                    cyc_nxt_s   = 1'b0;
                    state_nxt_s = ST_WR_REQ;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                end
            end
            ST_WR_REQ: begin
                if (!stb_r) begin
                    cyc_nxt_s = 1'b1;
                    stb_nxt_s = 1'b1;
                    we_nxt_s  = 1'b1;
                    adr_nxt_s = dst_w_r;
                    dat_nxt_s = mode_w_r ? rd_word_r : pattern_r;
                end else if (!wbm_stall_i) begin
                    stb_nxt_s   = 1'b0;
                    state_nxt_s = ST_WR_WAIT;
                end else begin
                    state_nxt_s = ST_WR_REQ;
                end
            end
            ST_WR_WAIT: begin
                if (wbm_ack_i) begin
                    wr_ack_s  = 1'b1;
                    cyc_nxt_s = 1'b0;
                    if (cnt_r == CNT_ONE) begin
                        fin_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (mode_w_r) begin
                        state_nxt_s = ST_RD_REQ;
                    end else begin
                        state_nxt_s = ST_WR_REQ;
                    end
                end else begin
                    state_nxt_s = ST_WR_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cyc_nxt_s   = 1'b0;
                stb_nxt_s   = 1'b0;
            end
        endcase
        // A bus error overrides any ack seen in the same cycle
        if (cyc_r && wbm_err_i) begin
            abort_s     = 1'b1;
            rd_ack_s    = 1'b0;
            wr_ack_s    = 1'b0;
            fin_s       = 1'b0;
            state_nxt_s = ST_IDLE;
            cyc_nxt_s   = 1'b0;
            stb_nxt_s   = 1'b0;
        end else begin
            abort_s = 1'b0;
        end
    end

    // Engine state, registered master outputs and working copies of SRC/DST/LEN
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cyc_r     <= 1'b0;
            stb_r     <= 1'b0;
            we_r      <= 1'b0;
            sel_r     <= 4'h0;
            adr_r     <= '0;
            dat_r     <= 32'h0;
            src_w_r   <= '0;
            dst_w_r   <= '0;
            cnt_r     <= '0;
            mode_w_r  <= 1'b0;
            rd_word_r <= 32'h0;
        end else begin
            state_r <= state_nxt_s;
            cyc_r   <= cyc_nxt_s;
            stb_r   <= stb_nxt_s;
            we_r    <= we_nxt_s;
            sel_r   <= stb_nxt_s ? 4'hF : 4'h0;
            adr_r   <= adr_nxt_s;
            dat_r   <= dat_nxt_s;
            if (start_ok_s) begin
                src_w_r  <= src_reg_r[MADR_W-1:0];
                dst_w_r  <= dst_reg_r[MADR_W-1:0];
                cnt_r    <= len_reg_r;
                mode_w_r <= wbs_dat_w[1];
            end else begin
                if (rd_ack_s) begin
                    src_w_r   <= src_w_r + ADR_ONE;
                    rd_word_r <= wbm_dat_i;
                end
                if (wr_ack_s) begin
                    dst_w_r <= dst_w_r + ADR_ONE;
                    cnt_r   <= cnt_r - CNT_ONE;
                end
            end
        end
    end

    // Software-visible registers; STATUS flags give engine set priority over W1C
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            ctrl_mode_r   <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            src_reg_r     <= 32'h0;
            dst_reg_r     <= 32'h0;
            len_reg_r     <= '0;
            pattern_r     <= 32'h0;
            irq_mask_r    <= 32'h0;
            irq_in_r      <= 32'h0;
        end else begin
            irq_in_r <= irq_in;
            if (slv_wr_s) begin
                case (reg_sel_s)
                    3'd0: begin
                        if (wbs_sel[0]) begin
                            ctrl_mode_r   <= wbs_dat_w[1];
                            ctrl_irq_en_r <= wbs_dat_w[2];
                        end
                    end
                    3'd2:    src_reg_r  <= byte_merge(src_reg_r, wbs_dat_w, wbs_sel);
                    3'd3:    dst_reg_r  <= byte_merge(dst_reg_r, wbs_dat_w, wbs_sel);
                    3'd4:    len_reg_r  <= len_merge_s[LEN_W-1:0];
                    3'd5:    pattern_r  <= byte_merge(pattern_r, wbs_dat_w, wbs_sel);
                    3'd6:    irq_mask_r <= byte_merge(irq_mask_r, wbs_dat_w, wbs_sel);
                    default: ;
                endcase
            end
            if (fin_s || abort_s) begin
                done_r <= 1'b1;
            end else if (start_ok_s || w1c_done_s) begin
                done_r <= 1'b0;
            end
            if (abort_s) begin
                err_r <= 1'b1;
            end else if (start_ok_s || w1c_err_s) begin
                err_r <= 1'b0;
            end
        end
    end

    // Register read multiplexer
    always_comb begin
        rd_mux_s = 32'h0;
        case (reg_sel_s)
            3'd0:    rd_mux_s = {29'd0, ctrl_irq_en_r, ctrl_mode_r, 1'b0};
            3'd1:    rd_mux_s = {29'd0, err_r, done_r, busy_s};
            3'd2:    rd_mux_s = src_reg_r;
            3'd3:    rd_mux_s = dst_reg_r;
            3'd4:    rd_mux_s = {{(32-LEN_W){1'b0}}, len_reg_r};
            3'd5:    rd_mux_s = pattern_r;
            3'd6:    rd_mux_s = irq_mask_r;
            3'd7:    rd_mux_s = irq_in_r & irq_mask_r;
            default: rd_mux_s = 32'h0;
        endcase
    end

    // Slave response: one-cycle ack with data
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            slv_ack_r <= 1'b0;
            slv_dat_r <= 32'h0;
        end else begin
            slv_ack_r <= slv_req_s;
            slv_dat_r <= (slv_req_s && !wbs_we) ? rd_mux_s : 32'h0;
        end
    end

    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_stb_o = stb_r;
    assign wbm_cyc_o = cyc_r;
    assign wbs_dat_r = slv_dat_r;
    assign wbs_ack   = slv_ack_r;
    assign wbs_stall = 1'b0;
    assign wbs_err   = 1'b0;
    assign irq_out   = (ctrl_irq_en_r & (done_r | err_r)) | (|(irq_in_r & irq_mask_r));

endmodule

// File: tb/tb_rm_wb_engine.sv
// Directed bench for rm_wb_engine: a behavioural bus slave scoreboards master writes
// against expectations queued by the stimulus; register reads are checked the same way.
module tb_rm_wb_engine;
    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] wbm_adr_o;
    logic [31:0] wbm_dat_o, wbs_dat_r;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o, wbs_stall, wbs_ack, wbs_err, irq_out;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0, wbm_stall_i = 1'b0, wbm_err_i = 1'b0;
    logic [19:0] wbs_adr = 20'h0;
    logic [31:0] wbs_dat_w = 32'h0;
    logic [3:0]  wbs_sel = 4'h0;
    logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic [31:0] irq_in = 32'h0;

    int vectors = 0, miscompares = 0;
    logic [31:0] mem [0:4095];
    logic [27:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [31:0] rd_exp_q[$];
    int stall_cfg = 0, stall_left = 0, err_on_rd = 0, rd_cnt = 0, wr_cnt = 0, req_cnt = 0;
    logic resp_pending = 1'b0, resp_err = 1'b0;
    logic [31:0] resp_dat = 32'h0;

    always #5 sys_clk = ~sys_clk;

    rm_wb_engine #(.MADR_W(28), .SADR_W(20), .LEN_W(16)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .wbm_stall_i(wbm_stall_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_err_i(wbm_err_i),
        .wbs_adr(wbs_adr), .wbs_dat_w(wbs_dat_w), .wbs_dat_r(wbs_dat_r), .wbs_sel(wbs_sel),
        .wbs_stall(wbs_stall), .wbs_cyc(wbs_cyc), .wbs_stb(wbs_stb), .wbs_ack(wbs_ack),
        .wbs_we(wbs_we), .wbs_err(wbs_err), .irq_in(irq_in), .irq_out(irq_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus slave model, acting on the falling edge: stalls, acks one cycle after acceptance
    always @(negedge sys_clk) begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        if (!rst_n) begin
            resp_pending = 1'b0;
            wbm_stall_i  = 1'b0;
        end else begin
            if (resp_pending) begin
                if (resp_err) wbm_err_i = 1'b1;
                else begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = resp_dat;
                end
                resp_pending = 1'b0;
            end
            if (wbm_cyc_o && wbm_stb_o) begin
                if (stall_left > 0) begin
                    wbm_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    wbm_stall_i  = 1'b0;
                    stall_left   = stall_cfg;
                    req_cnt++;
                    resp_pending = 1'b1;
                    resp_err     = 1'b0;
                    check("m_sel", {28'h0, wbm_sel_o}, 32'hF);
                    if (wbm_we_o) begin
                        wr_cnt++;
                        mem[wbm_adr_o[11:0]] = wbm_dat_o;
                        check("m_wr_expected", {31'h0, exp_adr_q.size() != 0}, 32'h1);
                        if (exp_adr_q.size() != 0) begin
                            check("m_wr_adr", {4'h0, wbm_adr_o}, {4'h0, exp_adr_q.pop_front()});
                            check("m_wr_dat", wbm_dat_o, exp_dat_q.pop_front());
                        end
                    end else begin
                        rd_cnt++;
                        if (rd_cnt == err_on_rd) resp_err = 1'b1;
                        resp_dat = mem[wbm_adr_o[11:0]];
                    end
                end
            end else begin
                wbm_stall_i = 1'b0;
            end
        end
    end

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] sel);
        @(negedge sys_clk);
        wbs_adr = {17'h1E000, a};
        wbs_dat_w = d; wbs_sel = sel; wbs_we = 1'b1; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        @(negedge sys_clk);
        check("s_wr_ack", {31'h0, wbs_ack}, 32'h1);
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        rd_exp_q.push_back(exp);
        @(negedge sys_clk);
        wbs_adr = {17'h0ABCD, a};
        wbs_sel = 4'hF; wbs_we = 1'b0; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        @(negedge sys_clk);
        check({tag, "_ack"}, {31'h0, wbs_ack}, 32'h1);
        check(tag, wbs_dat_r, rd_exp_q.pop_front());
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (irq_out !== 1'b1 && n < 400) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_irq_done"}, {31'h0, irq_out}, 32'h1);
        check({tag, "_cyc_low"}, {31'h0, wbm_cyc_o}, 32'h0);
        check({tag, "_exp_drained"}, exp_adr_q.size(), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, rq0, n;
        logic [31:0] src_v [0:2];
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        // 1: reset state
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
        check("rst_we", {31'h0, wbm_we_o}, 32'h0);
        check("rst_sel", {28'h0, wbm_sel_o}, 32'h0);
        check("rst_adr", {4'h0, wbm_adr_o}, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        check("rst_sack", {31'h0, wbs_ack}, 32'h0);
        check("rst_sdat", wbs_dat_r, 32'h0);
        check("rst_irq", {31'h0, irq_out}, 32'h0);
        check("rst_sstall_serr", {30'h0, wbs_stall, wbs_err}, 32'h0);
        rst_n = 1'b1;
        for (int r = 0; r < 8; r++) reg_rd(3'(r), 32'h0, "rst_reg");
        @(negedge sys_clk);
        check("s_ack_drop", {31'h0, wbs_ack}, 32'h0);

        // 2: fill
        reg_wr(3'd3, 32'h100, 4'hF);
        reg_wr(3'd4, 32'h4, 4'hF);
        reg_wr(3'd5, 32'hA5A5A5A5, 4'hF);
        for (int i = 0; i < 4; i++) begin
            exp_adr_q.push_back(28'h100 + 28'(i));
            exp_dat_q.push_back(32'hA5A5A5A5);
        end
        wr0 = wr_cnt;
        reg_wr(3'd0, 32'h5, 4'hF);
        wait_done("fill");
        check("fill_wr_cnt", wr_cnt - wr0, 32'd4);
        reg_rd(3'd1, 32'h2, "fill_status");

        // 3: copy with 2 stall cycles per request
        for (int i = 0; i < 3; i++) begin
            src_v[i] = $urandom;
            mem[12'h200 + 12'(i)] = src_v[i];
            exp_adr_q.push_back(28'h300 + 28'(i));
            exp_dat_q.push_back(src_v[i]);
        end
        stall_cfg = 2; stall_left = 2;
        reg_wr(3'd2, 32'h200, 4'hF);
        reg_wr(3'd3, 32'h300, 4'hF);
        reg_wr(3'd4, 32'h3, 4'hF);
        rq0 = req_cnt;
        reg_wr(3'd0, 32'h7, 4'hF);
        wait_done("copy");
        check("copy_req_cnt", req_cnt - rq0, 32'd6);
        for (int i = 0; i < 3; i++) check("copy_mem", mem[12'h300 + 12'(i)], src_v[i]);
        stall_cfg = 0; stall_left = 0;

        // 4: bus error on 3rd read
        for (int i = 0; i < 8; i++) mem[12'h400 + 12'(i)] = 32'hC0DE0000 + 32'(i);
        for (int i = 0; i < 2; i++) begin
            exp_adr_q.push_back(28'h500 + 28'(i));
            exp_dat_q.push_back(32'hC0DE0000 + 32'(i));
        end
        reg_wr(3'd2, 32'h400, 4'hF);
        reg_wr(3'd3, 32'h500, 4'hF);
        reg_wr(3'd4, 32'h8, 4'hF);
        rd_cnt = 0; err_on_rd = 3; wr0 = wr_cnt;
        reg_wr(3'd0, 32'h7, 4'hF);
        wait_done("err");
        check("err_wr_cnt", wr_cnt - wr0, 32'd2);
        reg_rd(3'd1, 32'h6, "err_status");
        err_on_rd = 0;
        reg_wr(3'd1, 32'h6, 4'hF);
        reg_rd(3'd1, 32'h0, "w1c_status");

        // 5: LEN=0, START while BUSY, address wrap
        reg_wr(3'd4, 32'h0, 4'hF);
        rq0 = req_cnt;
        check("len0_pre_irq", {31'h0, irq_out}, 32'h0);
        reg_wr(3'd0, 32'h5, 4'hF);
        check("len0_done_next", {31'h0, irq_out}, 32'h1);
        check("len0_no_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        reg_rd(3'd1, 32'h2, "len0_status");
        check("len0_no_req", req_cnt - rq0, 32'd0);

        reg_wr(3'd3, 32'h600, 4'hF);
        reg_wr(3'd4, 32'h3, 4'hF);
        for (int i = 0; i < 3; i++) begin
            exp_adr_q.push_back(28'h600 + 28'(i));
            exp_dat_q.push_back(32'hA5A5A5A5);
        end
        stall_cfg = 6; stall_left = 6; rq0 = req_cnt;
        reg_wr(3'd0, 32'h5, 4'hF);
        reg_rd(3'd1, 32'h1, "busy_status");
        reg_wr(3'd0, 32'h7, 4'hF);
        wait_done("busy_start");
        check("busy_req_cnt", req_cnt - rq0, 32'd3);
        reg_rd(3'd0, 32'h6, "ctrl_readback");
        stall_cfg = 0; stall_left = 0;

        reg_wr(3'd3, 32'h0FFFFFFF, 4'hF);
        reg_wr(3'd4, 32'h2, 4'hF);
        exp_adr_q.push_back(28'hFFFFFFF); exp_dat_q.push_back(32'hA5A5A5A5);
        exp_adr_q.push_back(28'h0000000); exp_dat_q.push_back(32'hA5A5A5A5);
        reg_wr(3'd0, 32'h5, 4'hF);
        wait_done("wrap");

        // byte-lane write
        reg_wr(3'd5, 32'h11223344, 4'b0101);
        reg_rd(3'd5, 32'hA522A544, "byte_sel");

        // 6: IRQ aggregation
        reg_wr(3'd0, 32'h0, 4'hF);
        check("irq_en_off", {31'h0, irq_out}, 32'h0);
        @(negedge sys_clk);
        irq_in = 32'h30;
        reg_wr(3'd6, 32'h10, 4'hF);
        check("irq_masked_on", {31'h0, irq_out}, 32'h1);
        reg_rd(3'd7, 32'h10, "irq_pend");
        reg_wr(3'd6, 32'h0, 4'hF);
        check("irq_mask0", {31'h0, irq_out}, 32'h0);
        irq_in = 32'h0;

        // reset in the middle of a copy
        reg_wr(3'd2, 32'h200, 4'hF);
        reg_wr(3'd3, 32'h700, 4'hF);
        reg_wr(3'd4, 32'h4, 4'hF);
        wr0 = wr_cnt;
        reg_wr(3'd0, 32'h7, 4'hF);
        n = 0;
        while (wbm_cyc_o !== 1'b1 && n < 20) begin
            @(negedge sys_clk);
            n++;
        end
        check("midrst_cyc_seen", {31'h0, wbm_cyc_o}, 32'h1);
        rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
        check("midrst_stb", {31'h0, wbm_stb_o}, 32'h0);
        rst_n = 1'b1;
        reg_rd(3'd1, 32'h0, "midrst_status");
        reg_rd(3'd2, 32'h0, "midrst_src");
        check("midrst_no_wr", wr_cnt - wr0, 32'd0);
        check("midrst_irq", {31'h0, irq_out}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
